// File: rtl/bram_ring_ctrl.sv
// Byte FIFO built on a 1K x 8 dual-port block RAM: port A writes, port B reads.
// A 2-entry skid register hides the RAM's registered read latency.
module bram_ring_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_datain_a,
  output logic              ram_wr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_datain_b,
  output logic              ram_wr_b,
  input  logic [DATA_W-1:0] ram_dataout_b,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              rd_pend;
  logic [1:0]        skid_cnt;
  logic [DATA_W-1:0] skid_tail;
  logic              push;
  logic              pop;
  logic              fetch;

  assign in_ready  = rst_n & ~flush & (level != DEPTH_L);
  assign push      = in_valid & in_ready;
  assign out_valid = (skid_cnt != 2'd0);
  assign pop       = out_valid & out_ready;

  // Only fetch when the skid is guaranteed a free slot once the RAM data lands.
  assign fetch = (mem_cnt != '0) &&
                 (({1'b0, skid_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));

  assign ram_wr_a     = push;
  assign ram_addr_a   = wr_ptr;
  assign ram_datain_a = in_data;
  assign ram_addr_b   = rd_ptr;
  assign ram_datain_b = '0;
  assign ram_wr_b     = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      rd_pend   <= 1'b0;
      skid_cnt  <= 2'd0;
      skid_tail <= '0;
      level     <= '0;
      out_data  <= '0;
    end else if (flush) begin
      // out_data deliberately keeps its last value across a flush
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      rd_pend   <= 1'b0;
      skid_cnt  <= 2'd0;
      level     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(fetch);
      rd_pend <= fetch;
      level   <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

      // out_data is the skid head; skid_tail is the second entry
      case ({pop, rd_pend})
        2'b11: begin
          if (skid_cnt == 2'd2) begin
            out_data  <= skid_tail;
            skid_tail <= ram_dataout_b;
          end else begin
            out_data <= ram_dataout_b;
          end
        end
        2'b10: begin
          if (skid_cnt == 2'd2) out_data <= skid_tail;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b01: begin
          if (skid_cnt == 2'd0) out_data <= ram_dataout_b;
          else skid_tail <= ram_dataout_b;
          skid_cnt <= skid_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bram_ring_ctrl.md
Name: bram_ring_ctrl

Overview:
- Ring-buffer controller that turns the 1K x 8 dual-port block RAM into a byte FIFO with valid/ready streams on both sides.
- Drives port A for writes from the upstream byte producer, and port B for reads.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry output skid register, so a continuously ready consumer sees 1 byte/cycle.
- Sits between the packet/byte source and the downstream consumer (e.g. serializer).

Parameters:
- ADDR_W, 10, RAM address width; ring depth DEPTH = 2**ADDR_W (1024 bytes).
- DATA_W, 8, byte width; must match the RAM data width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous clear of all buffered content.
- in_valid  input  1  upstream byte valid.
- in_data  input  DATA_W  upstream byte.
- in_ready  output  1  controller can accept a byte this cycle.
- out_valid  output  1  out_data holds a valid byte.
- out_data  output  DATA_W  oldest buffered byte.
- out_ready  input  1  consumer accepts out_data this cycle.
- ram_addr_a  output  ADDR_W  RAM port A address (write pointer).
- ram_datain_a  output  DATA_W  RAM port A write data (= in_data).
- ram_wr_a  output  1  RAM port A write strobe.
- ram_addr_b  output  ADDR_W  RAM port B address (read pointer).
- ram_datain_b  output  DATA_W  tied to 0.
- ram_wr_b  output  1  tied to 0.
- ram_dataout_b  input  DATA_W  RAM port B registered read data.
- level  output  ADDR_W+1  total bytes held (RAM + in-flight + skid), 0..DEPTH.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - wr_ptr=0, rd_ptr=0, mem_cnt=0, rd_pend=0, skid empty.
  - out_valid=0, out_data=0, level=0, ram_wr_a=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
- Write: push = in_valid & in_ready.
  - ram_wr_a = push; ram_addr_a = wr_ptr; wr_ptr += 1 mod DEPTH on push.
  - in_ready = (level < DEPTH) & rst_n & ~flush.
- mem_cnt counts bytes written but not yet fetched. It increments the cycle after the push (registered), so the RAM is never read at an address being written in the same cycle. Read-during-write hazard is excluded by construction.
- Fetch:
  - fetch = (mem_cnt > 0) & (skid_cnt + rd_pend - pop < 2), where pop = out_valid & out_ready.
  - ram_addr_b = rd_ptr. On fetch: rd_ptr += 1 mod DEPTH, mem_cnt -= 1, rd_pend <= 1; otherwise rd_pend <= 0.
- Capture: when rd_pend=1, ram_dataout_b is written into the skid tail on that cycle's edge.
- Skid: 2-entry register FIFO.
  - out_data/out_valid present the head entry.
  - pop removes the head.
  - Simultaneous pop and capture are both honoured in one cycle.
- Latency:
  - Byte pushed at cycle N is first visible on out_valid at cycle N+3 (N+1 mem_cnt update/fetch, N+2 RAM data, N+3 skid).
  - Throughput 1 byte/cycle when out_ready is held high.
- level: +1 per push, −1 per pop, unchanged when both occur; registered.
- Full: level=DEPTH → in_ready=0; in_valid is ignored (no write, no pointer move).
- Empty: level=0 → out_valid=0; out_data holds its last value.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no gap; byte order is preserved across the wrap.
- Flush (rst_n=1, flush=1): same clear as reset, except out_data holds its value.
  - A read in flight on that cycle is discarded.
  - in_valid is ignored that cycle.
  - Flush has priority over push/pop.
- Reset or flush mid-operation: buffered bytes are lost; the first byte pushed afterwards goes to address 0.
- Back-to-back push/pop at level=DEPTH: pop frees a slot, but in_ready is only reasserted the following cycle (registered level).

Test Plan:
- Single byte: push 0xA5 at cycle 0 with out_ready=1 → ram_wr_a=1, addr_a=0 at cycle 0; out_valid=1, out_data=0xA5 at cycle 3; level 1→0 after the pop.
- Streaming: push 0x00..0xFF continuously with out_ready=1 → out_data yields 0x00..0xFF in order, one per cycle with no bubbles after the first; level stays ≤3.
- Full/wrap:
  - With out_ready=0, push 1024 bytes → level=1024, in_ready=0; byte 1025 is not written (ram_wr_a stays 0).
  - Then drain 512, push 512 more → addr_a wraps 1023→0; the 1024 bytes read out are in push order.
- Backpressure: toggle out_ready 1,0,0,1 with in_valid=1 → no duplicated or dropped bytes; out_data is stable while out_valid=1 & out_ready=0.
- Flush with a read pending and 2 skid entries → next cycle out_valid=0, level=0, rd_ptr=wr_ptr=0; the next push of 0x3C appears as the sole output.
- Reset mid-stream (rst_n low for 1 cycle at level=10) → in_ready=0 during reset, out_valid=0, level=0; in_ready=1 the cycle after release.
